// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller with a private E/M/W destination scoreboard and a multi-cycle MDU stall.
// Optional macro HAZARD_STALL_CNT_EN adds a saturating StallCount output.
module hazard_scoreboard #(
    parameter int REG_AW     = 5,
    parameter int MDU_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] RsD,
    input  logic [REG_AW-1:0] RtD,
    input  logic              UseRsD,
    input  logic              UseRtD,
    input  logic [REG_AW-1:0] WriteRegD,
    input  logic              RegWriteD,
    input  logic              MemtoRegD,
    input  logic              MduD,
    input  logic              BranchD,
    input  logic              BranchTakenD,
    input  logic              JumpD,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              ForwardAD,
    output logic              ForwardBD,
    output logic [1:0]        ForwardAE,
`ifdef HAZARD_STALL_CNT_EN
    output logic [15:0]       StallCount,
`endif
    output logic [1:0]        ForwardBE
);

    localparam logic [3:0] MDU_LOAD = 4'(MDU_CYCLES - 1);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              use_rs;
        logic              use_rt;
        logic [REG_AW-1:0] dest;
        logic              regwrite;
        logic              memtoreg;
        logic              mdu;
    } e_ent_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic              regwrite;
        logic              memtoreg;
    } m_ent_t;

    // W only feeds the ResultW forward, which is already load-muxed, so no memtoreg bit.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic              regwrite;
    } w_ent_t;

    e_ent_t     e_q, e_d;
    m_ent_t     m_q, m_d;
    w_ent_t     w_q, w_d;
    logic [3:0] mdu_cnt_q, mdu_cnt_d;

    logic lwstall, branchstall, mdustall, stall_d;
    logic e_rs_hit, e_rt_hit, m_rs_hit, m_rt_hit;

    function automatic logic wr_match(input logic v, input logic rw,
                                      input logic [REG_AW-1:0] dest,
                                      input logic [REG_AW-1:0] src);
        return v & rw & (dest != '0) & (dest == src);
    endfunction

    always_comb begin
        e_rs_hit    = wr_match(e_q.valid, e_q.regwrite, e_q.dest, RsD);
        e_rt_hit    = wr_match(e_q.valid, e_q.regwrite, e_q.dest, RtD);
        m_rs_hit    = wr_match(m_q.valid, m_q.regwrite, m_q.dest, RsD);
        m_rt_hit    = wr_match(m_q.valid, m_q.regwrite, m_q.dest, RtD);
        lwstall     = e_q.memtoreg & ((UseRsD & e_rs_hit) | (UseRtD & e_rt_hit));
        branchstall = BranchD & (e_rs_hit | e_rt_hit | (m_q.memtoreg & (m_rs_hit | m_rt_hit)));
        // The counter is only ever non-zero while the MDU op sits frozen in E.
        mdustall    = (mdu_cnt_q != 4'd0) & e_q.mdu;
        stall_d     = lwstall | branchstall | mdustall;
    end

    assign StallF    = stall_d;
    assign StallD    = stall_d;
    assign StallE    = mdustall;
    assign FlushM    = mdustall;
    assign FlushE    = (lwstall | branchstall) & ~mdustall;
    assign FlushD    = (JumpD | (BranchD & BranchTakenD)) & ~stall_d;
    assign ForwardAD = BranchD & m_rs_hit & ~m_q.memtoreg;
    assign ForwardBD = BranchD & m_rt_hit & ~m_q.memtoreg;

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (e_q.use_rs & wr_match(m_q.valid, m_q.regwrite, m_q.dest, e_q.rs))
            ForwardAE = 2'b10;
        else if (e_q.use_rs & wr_match(w_q.valid, w_q.regwrite, w_q.dest, e_q.rs))
            ForwardAE = 2'b01;
        if (e_q.use_rt & wr_match(m_q.valid, m_q.regwrite, m_q.dest, e_q.rt))
            ForwardBE = 2'b10;
        else if (e_q.use_rt & wr_match(w_q.valid, w_q.regwrite, w_q.dest, e_q.rt))
            ForwardBE = 2'b01;
    end

    always_comb begin
        w_d = '{valid: m_q.valid, dest: m_q.dest, regwrite: m_q.regwrite};
        m_d = '{valid: e_q.valid, dest: e_q.dest, regwrite: e_q.regwrite, memtoreg: e_q.memtoreg};
        if (FlushM)
            m_d = '0;
        e_d = '{valid: 1'b1, rs: RsD, rt: RtD, use_rs: UseRsD, use_rt: UseRtD,
                dest: WriteRegD, regwrite: RegWriteD, memtoreg: MemtoRegD, mdu: MduD};
        if (StallE)
            e_d = e_q;
        else if (FlushE)
            e_d = '0;
        mdu_cnt_d = mdu_cnt_q;
        if (!StallE && !FlushE && MduD)
            mdu_cnt_d = MDU_LOAD;
        else if (mdu_cnt_q != 4'd0)
            mdu_cnt_d = mdu_cnt_q - 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q       <= '0;
            m_q       <= '0;
            w_q       <= '0;
            mdu_cnt_q <= 4'd0;
        end else begin
            e_q       <= e_d;
            m_q       <= m_d;
            w_q       <= w_d;
            mdu_cnt_q <= mdu_cnt_d;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_d && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt_q <= 16'd0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-cycle bench: driver queues hand-computed output vectors, a negedge monitor pops and compares.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] RsD, RtD, WriteRegD;
    logic       UseRsD, UseRtD, RegWriteD, MemtoRegD, MduD, BranchD, BranchTakenD, JumpD;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardAD, ForwardBD;
    logic [1:0] ForwardAE, ForwardBE;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_AW(5), .MDU_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .RsD(RsD), .RtD(RtD), .UseRsD(UseRsD), .UseRtD(UseRtD),
        .WriteRegD(WriteRegD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MduD(MduD),
        .BranchD(BranchD), .BranchTakenD(BranchTakenD), .JumpD(JumpD),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ForwardAE(ForwardAE),
`ifdef HAZARD_STALL_CNT_EN
        .StallCount(stall_count),
`endif
        .ForwardBE(ForwardBE)
    );

`ifndef HAZARD_STALL_CNT_EN
    assign stall_count = 16'd0;
`endif

    // Output vector: {SF,SD,SE,FD,FE,FM,FAD,FBD,FAE[1:0],FBE[1:0]}
    localparam logic [11:0] Z    = 12'h000;
    localparam logic [11:0] S_LW = 12'hC80;
    localparam logic [11:0] S_MD = 12'hE40;
    localparam logic [11:0] FD   = 12'h100;
    localparam logic [11:0] FAD  = 12'h020;
    localparam logic [11:0] AE01 = 12'h004;
    localparam logic [11:0] AE10 = 12'h008;
    localparam logic [11:0] BE10 = 12'h002;

    typedef struct packed {
        logic [4:0] rs, rt;
        logic       urs, urt;
        logic [4:0] wr;
        logic       rw, m2r, mdu, br, bt, j;
    } d_t;

    typedef struct packed {
        logic [11:0] o;
        logic [15:0] sc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    compared = 0;
    int    mismatched = 0;
    logic [15:0] exp_sc = 16'd0;

    localparam d_t NOP = '0;

    function automatic d_t alu(int rd, int rs, int rt);
        d_t d = '0;
        d.rs = 5'(rs); d.rt = 5'(rt); d.urs = 1'b1; d.urt = 1'b1;
        d.wr = 5'(rd); d.rw = 1'b1;
        return d;
    endfunction

    function automatic d_t lw(int rt, int base);
        d_t d = '0;
        d.rs = 5'(base); d.urs = 1'b1; d.wr = 5'(rt); d.rw = 1'b1; d.m2r = 1'b1;
        return d;
    endfunction

    function automatic d_t beq(int rs, int rt, logic taken);
        d_t d = '0;
        d.rs = 5'(rs); d.rt = 5'(rt); d.urs = 1'b1; d.urt = 1'b1;
        d.br = 1'b1; d.bt = taken;
        return d;
    endfunction

    function automatic d_t mdu(int rs, int rt);
        d_t d = '0;
        d.rs = 5'(rs); d.rt = 5'(rt); d.urs = 1'b1; d.urt = 1'b1; d.mdu = 1'b1;
        return d;
    endfunction

    function automatic d_t jmp();
        d_t d = '0;
        d.j = 1'b1;
        return d;
    endfunction

    task automatic cyc(input string nm, input d_t d, input logic [11:0] e, input logic rst);
        exp_t x;
        reset = rst;
        RsD = d.rs; RtD = d.rt; UseRsD = d.urs; UseRtD = d.urt;
        WriteRegD = d.wr; RegWriteD = d.rw; MemtoRegD = d.m2r; MduD = d.mdu;
        BranchD = d.br; BranchTakenD = d.bt; JumpD = d.j;
        if (rst) exp_sc = 16'd0;
        x.o = e;
        x.sc = exp_sc;
        exp_q.push_back(x);
        name_q.push_back(nm);
        if (!rst && e[10] && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  x;
            string nm;
            logic [11:0] act;
            x  = exp_q.pop_front();
            nm = name_q.pop_front();
            act = {StallF, StallD, StallE, FlushD, FlushE, FlushM,
                   ForwardAD, ForwardBD, ForwardAE, ForwardBE};
            compared++;
            if (act !== x.o) begin
                mismatched++;
                $display("FAIL %s: outputs got %03h want %03h", nm, act, x.o);
            end else begin
                $display("ok   %s: outputs %03h", nm, act);
            end
`ifdef HAZARD_STALL_CNT_EN
            compared++;
            if (stall_count !== x.sc) begin
                mismatched++;
                $display("FAIL %s.cnt: StallCount got %0d want %0d", nm, stall_count, x.sc);
            end
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        RsD = '0; RtD = '0; WriteRegD = '0; UseRsD = 0; UseRtD = 0; RegWriteD = 0;
        MemtoRegD = 0; MduD = 0; BranchD = 0; BranchTakenD = 0; JumpD = 0;
        @(posedge clk); #1;
        cyc("reset_state", NOP, Z, 1'b1);

        // load-use
        cyc("lu_lw",    lw(2, 1),      Z,    1'b0);
        cyc("lu_stall", alu(3, 2, 4),  S_LW, 1'b0);
        cyc("lu_retry", alu(3, 2, 4),  Z,    1'b0);
        cyc("lu_fwdW",  NOP,           AE01, 1'b0);
        cyc("lu_idle",  NOP,           Z,    1'b0);
        // ALU->ALU forward from M
        cyc("ex_add",   alu(5, 1, 1),  Z,    1'b0);
        cyc("ex_sub",   alu(6, 5, 5),  Z,    1'b0);
        cyc("ex_fwdM",  NOP,           AE10 | BE10, 1'b0);
        cyc("ex_idle",  NOP,           Z,    1'b0);
        // branch on freshly computed register, taken
        cyc("br_add",   alu(7, 1, 1),  Z,    1'b0);
        cyc("br_stall", beq(7, 0, 1'b1), S_LW, 1'b0);
        cyc("br_fwd",   beq(7, 0, 1'b1), FD | FAD, 1'b0);
        cyc("br_e",     NOP,           AE01, 1'b0);
        cyc("br_idle",  NOP,           Z,    1'b0);
        // load feeding a branch: two stall cycles, no W->D forward
        cyc("lb_lw",    lw(2, 1),      Z,    1'b0);
        cyc("lb_s1",    beq(2, 2, 1'b0), S_LW, 1'b0);
        cyc("lb_s2",    beq(2, 2, 1'b0), S_LW, 1'b0);
        cyc("lb_go",    beq(2, 2, 1'b0), Z,  1'b0);
        cyc("lb_e",     NOP,           Z,    1'b0);
        // jump
        cyc("jmp",      jmp(),         FD,   1'b0);
        cyc("j_idle",   NOP,           Z,    1'b0);
        // MDU stall, jump in D held without flush until release
        cyc("mdu_in",   mdu(1, 1),     Z,    1'b0);
        cyc("mdu_s1",   jmp(),         S_MD, 1'b0);
        cyc("mdu_s2",   jmp(),         S_MD, 1'b0);
        cyc("mdu_s3",   jmp(),         S_MD, 1'b0);
        cyc("mdu_rel",  jmp(),         FD,   1'b0);
        cyc("mdu_idle", NOP,           Z,    1'b0);
        // register 0 is never a hazard
        cyc("z_w",      alu(0, 1, 1),  Z,    1'b0);
        cyc("z_r",      alu(10, 0, 0), Z,    1'b0);
        cyc("z_e",      NOP,           Z,    1'b0);
        cyc("z_lw",     lw(0, 1),      Z,    1'b0);
        cyc("z_lr",     alu(11, 0, 0), Z,    1'b0);
        cyc("z_idle",   NOP,           Z,    1'b0);
        // reset in the middle of an MDU stall
        cyc("rm_in",    mdu(1, 1),     Z,    1'b0);
        cyc("rm_s1",    alu(9, 1, 1),  S_MD, 1'b0);
        cyc("rm_rst",   alu(9, 1, 1),  Z,    1'b1);
        cyc("rm_rel",   alu(9, 1, 1),  Z,    1'b0);
        cyc("rm_idle",  NOP,           Z,    1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
